// File: rtl/gear_pkg.sv
// gear_pkg: shared state type, lever codes and led index helpers for the gear selector.
package gear_pkg;
  typedef enum logic [2:0] {PARK, REVERSE, NEUTRAL, DRIVE, EXIT_DOWN} state_t;
  localparam logic [3:0] LEV_D = 4'b0001;
  localparam logic [3:0] LEV_N = 4'b0010;
  localparam logic [3:0] LEV_R = 4'b0100;
  localparam logic [3:0] LEV_P = 4'b1000;
  function automatic int idx_p(int n);
    return n;
  endfunction
  function automatic int idx_n(int n);
    return n + 1;
  endfunction
  function automatic int idx_r(int n);
    return n + 2;
  endfunction
  function automatic state_t lev_state(logic [3:0] lev);
    return lev == LEV_R ? REVERSE : lev == LEV_N ? NEUTRAL : lev == LEV_D ? DRIVE : PARK;
  endfunction
  function automatic int state_idx(state_t s, int n);
    return s == REVERSE ? idx_r(n) : s == NEUTRAL ? idx_n(n) : idx_p(n);
  endfunction
endpackage

// File: rtl/gear_selector_fsm_lever_debounce.sv
// lever_debounce: accepts a lever value after DEBOUNCE_CYCLES identical samples, flags held invalid patterns.
module lever_debounce
  import gear_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  output logic [3:0] lever_req,
  output logic       lever_fault
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  logic [3:0] last;
  logic [CW-1:0] cnt, cnt_n;
  logic valid;
  always_comb begin
    cnt_n = sw != last ? CW'(1) : cnt == CMAX ? cnt : cnt + CW'(1);
    valid = sw != 4'd0 && (sw & (sw - 4'd1)) == 4'd0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      last <= LEV_P;
      cnt <= '0;
      lever_req <= LEV_P;
      lever_fault <= 1'b0;
    end else begin
      last <= sw;
      cnt <= cnt_n;
      if (cnt_n == CMAX) begin
        lever_req <= valid ? sw : lever_req;
        lever_fault <= !valid;
      end
    end
endmodule

// File: rtl/gear_selector_fsm.sv
// gear_selector_fsm: debounced P/R/N/D lever, brake interlock, dwell-timed auto-shifting and one-hot leds.
module gear_selector_fsm
  import gear_pkg::*;
#(
  parameter int NUM_DRIVE_GEARS = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SHIFT_DELAY = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [3:0]                           sw,
  input  logic                                 brake,
  input  logic                                 throttle,
  output logic [NUM_DRIVE_GEARS+2:0]           led,
  output logic [$clog2(NUM_DRIVE_GEARS+1)-1:0] gear,
  output logic                                 shifting,
  output logic                                 lever_fault
);
  localparam int GW = $clog2(NUM_DRIVE_GEARS + 1);
  localparam int CW = $clog2(SHIFT_DELAY);
  localparam int LW = NUM_DRIVE_GEARS + 3;
  localparam logic [GW-1:0] G1 = GW'(1);
  localparam logic [GW-1:0] GN = GW'(NUM_DRIVE_GEARS);
  localparam logic [CW-1:0] CMAX = CW'(SHIFT_DELAY - 1);
  logic [3:0] lever_req;
  state_t state, state_n, rs;
  logic [GW-1:0] gear_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LW-1:0] led_n;
  logic expire, drv_n;
  lever_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .lever_req(lever_req),
    .lever_fault(lever_fault)
  );
  // EXIT_DOWN's target is simply the live P/R request, so retargeting needs no extra state.
  always_comb begin
    rs = lev_state(lever_req);
    expire = cnt == CMAX;
    state_n = state;
    gear_n = gear;
    cnt_n = expire ? '0 : cnt + CW'(1);
    case (state)
      PARK: state_n = brake ? rs : PARK;
      NEUTRAL: state_n = rs;
      REVERSE: state_n = rs == DRIVE && !brake ? REVERSE : rs;
      DRIVE:
        if (rs == NEUTRAL) state_n = NEUTRAL;
        else if (rs != DRIVE) state_n = gear == G1 ? rs : EXIT_DOWN;
        else if (expire) gear_n = throttle ? (gear < GN ? gear + G1 : gear) : (gear > G1 ? gear - G1 : gear);
      EXIT_DOWN:
        if (rs == DRIVE || rs == NEUTRAL) state_n = rs;
        else if (expire && gear == G1) state_n = rs;
        else if (expire) gear_n = gear - G1;
      default: state_n = PARK;
    endcase
    drv_n = state_n == DRIVE || state_n == EXIT_DOWN;
    if (state_n != state) cnt_n = '0;
    if (!drv_n) gear_n = '0;
    else if (gear == '0) gear_n = G1;
    led_n = drv_n ? LW'(1) << (gear_n - G1) : LW'(1) << state_idx(state_n, NUM_DRIVE_GEARS);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= PARK;
      gear <= '0;
      cnt <= '0;
      shifting <= 1'b0;
      led <= LW'(1) << idx_p(NUM_DRIVE_GEARS);
    end else begin
      state <= state_n;
      gear <= gear_n;
      cnt <= cnt_n;
      shifting <= state_n == EXIT_DOWN;
      led <= led_n;
    end
endmodule

// File: tb/tb_gear_selector_fsm.sv
// tb_gear_selector_fsm: directed scenarios plus random lever/brake/throttle traffic against a behavioural model.
module tb_gear_selector_fsm;
  localparam int NG = 4;
  localparam int DC = 4;
  localparam int SD = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sw = 4'b1000;
  logic brake = 1'b0;
  logic throttle = 1'b0;
  logic [NG+2:0] led;
  logic [2:0] gear;
  logic shifting, lever_fault;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] hist[$];
  byte m_req, mode;
  bit m_fault;
  int mg, md;

  gear_selector_fsm #(.NUM_DRIVE_GEARS(NG), .DEBOUNCE_CYCLES(DC), .SHIFT_DELAY(SD)) dut (
    .clk(clk), .rst(rst), .sw(sw), .brake(brake), .throttle(throttle),
    .led(led), .gear(gear), .shifting(shifting), .lever_fault(lever_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic byte lev(logic [3:0] s);
    return s == 4'b1000 ? "P" : s == 4'b0100 ? "R" : s == 4'b0010 ? "N" : s == 4'b0001 ? "D" : "?";
  endfunction

  // Behavioural model: mode letters, gear as an integer, dwell as cycles since last gear change/entry.
  task automatic model_edge();
    byte nm;
    int ng;
    bit up, stable;
    if (rst) begin
      hist.delete();
      m_req = "P"; m_fault = 0; mode = "P"; mg = 0; md = 0;
      return;
    end
    up = md == SD - 1;
    nm = mode;
    ng = mg;
    if (mode == "P" && brake) nm = m_req;
    if (mode == "N") nm = m_req;
    if (mode == "R" && (m_req != "D" || brake)) nm = m_req;
    if (mode == "D") begin
      if (m_req == "N" || ((m_req == "P" || m_req == "R") && mg == 1)) nm = m_req;
      else if (m_req != "D") nm = "X";
      else if (up && throttle && mg < NG) ng = mg + 1;
      else if (up && !throttle && mg > 1) ng = mg - 1;
    end
    if (mode == "X") begin
      if (m_req == "D" || m_req == "N") nm = m_req;
      else if (up && mg == 1) nm = m_req;
      else if (up) ng = mg - 1;
    end
    md = (nm != mode || up) ? 0 : md + 1;
    if (nm == "D" && mode != "D" && mode != "X") ng = 1;
    if (nm != "D" && nm != "X") ng = 0;
    mode = nm;
    mg = ng;
    hist.push_back(sw);
    if (hist.size() > DC) void'(hist.pop_front());
    stable = hist.size() == DC;
    foreach (hist[i]) if (hist[i] != hist[0]) stable = 0;
    if (stable) begin
      m_fault = lev(sw) == "?";
      if (!m_fault) m_req = lev(sw);
    end
  endtask

  function automatic logic [31:0] exp_led();
    if (mode == "D" || mode == "X") return 32'd1 << (mg - 1);
    if (mode == "N") return 32'd1 << (NG + 1);
    if (mode == "R") return 32'd1 << (NG + 2);
    return 32'd1 << NG;
  endfunction

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("led", 32'(led), exp_led());
      chk("gear", 32'(gear), 32'(mg));
      chk("shifting", 32'(shifting), 32'(mode == "X"));
      chk("lever_fault", 32'(lever_fault), 32'(m_fault));
    end
  endtask

  initial begin
    step(2);
    chk("rst_led", 32'(led), 32'b0010000);
    chk("rst_gear", 32'(gear), 0);
    chk("rst_shift", 32'(shifting), 0);
    chk("rst_fault", 32'(lever_fault), 0);
    rst = 0; brake = 1; sw = 4'b0001;
    step(4);
    chk("p_hold_e4", 32'(led), 32'b0010000);
    step(1);
    chk("d_entry_led", 32'(led), 32'b0000001);
    chk("d_entry_gear", 32'(gear), 1);
    sw = 4'b1000;
    step(5);
    chk("back_park", 32'(led), 32'b0010000);
    brake = 0; sw = 4'b0001;
    step(20);
    chk("interlock_hold", 32'(led), 32'b0010000);
    brake = 1;
    step(1);
    chk("interlock_release", 32'(gear), 1);
    throttle = 1;
    step(8);
    chk("up_g2", 32'(gear), 2);
    step(8);
    chk("up_g3", 32'(gear), 3);
    step(8);
    chk("up_g4", 32'(gear), 4);
    step(16);
    chk("sat_g4", 32'(led), 32'b0001000);
    throttle = 0;
    step(8);
    chk("down_g3", 32'(gear), 3);
    throttle = 1;
    step(8);
    chk("re_g4", 32'(gear), 4);
    sw = 4'b1000;
    step(5);
    chk("exit_start_shift", 32'(shifting), 1);
    chk("exit_start_gear", 32'(gear), 4);
    step(8);
    chk("exit_g3", 32'(gear), 3);
    step(8);
    chk("exit_g2", 32'(gear), 2);
    step(8);
    chk("exit_g1", 32'(gear), 1);
    step(7);
    chk("exit_last_shift", 32'(shifting), 1);
    step(1);
    chk("exit_park_led", 32'(led), 32'b0010000);
    chk("exit_park_shift", 32'(shifting), 0);
    sw = 4'b0001;
    step(5);
    step(24);
    chk("again_g4", 32'(gear), 4);
    sw = 4'b1000;
    step(13);
    chk("abort_pre_g3", 32'(gear), 3);
    sw = 4'b0001;
    step(5);
    chk("abort_led", 32'(led), 32'b0000100);
    chk("abort_shift", 32'(shifting), 0);
    step(3);
    sw = 4'b0011;
    step(4);
    chk("fault_set", 32'(lever_fault), 1);
    chk("fault_keep_gear", 32'(gear), 3);
    rst = 1;
    step(1);
    chk("midrst_led", 32'(led), 32'b0010000);
    chk("midrst_gear", 32'(gear), 0);
    chk("midrst_fault", 32'(lever_fault), 0);
    rst = 0;
    for (int s = 0; s < 200; s++) begin
      int r;
      r = $urandom_range(0, 11);
      sw = r < 5 ? 4'b0001 : r < 7 ? 4'b1000 : r < 8 ? 4'b0100 : r < 9 ? 4'b0010 : 4'($urandom);
      brake = $urandom_range(0, 2) != 0;
      throttle = $urandom_range(0, 1) == 1;
      rst = $urandom_range(0, 60) == 0;
      step(rst ? 1 : $urandom_range(1, 30));
      rst = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
